// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - MEM-stage, tag-array, data-RAM and memory-bus signals of the data cache controller
interface dcache_ctrl_if;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_req;
  logic        tag_hit;
  logic        tag_write_back;
  logic [31:0] tag_last_addr;
  logic        tag_wr;
  logic        cache_ok;
  logic [11:0] data_idx;
  logic [31:0] data_rdata;
  logic        data_we;
  logic [3:0]  data_wsel;
  logic [31:0] data_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    input  mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    input  tag_hit, tag_write_back, tag_last_addr, data_rdata, bus_rdata, bus_ack,
    output mem_rdata, stall_req, tag_wr, cache_ok,
    output data_idx, data_we, data_wsel, data_wdata,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_sel
  );

  modport slave (
    output mem_ce, mem_we, mem_addr, mem_sel, mem_wdata,
    output tag_hit, tag_write_back, tag_last_addr, data_rdata, bus_rdata, bus_ack,
    input  mem_rdata, stall_req, tag_wr, cache_ok,
    input  data_idx, data_we, data_wsel, data_wdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel
  );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped data cache sequencer: hit/miss, dirty write-back, line refill, uncached bypass
module dcache_ctrl #(
  parameter int         LINE_WORDS   = 16,
  parameter logic [2:0] UNCACHED_SEG = 3'b101
) (
  input logic           clk,
  input logic           rst,
  dcache_ctrl_if.master io
);
  localparam int            CW   = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WB     = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_UNC    = 3'd4;

  logic [2:0]    state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          ack_gap, unc_done;
  logic [31:0]   unc_rdata;
  logic          uncached, bus_phase, req, beat;
  logic [7:0]    index;

  assign index     = io.mem_addr[13:6];
  assign uncached  = io.mem_addr[31:29] == UNCACHED_SEG;
  assign bus_phase = (state == S_WB) || (state == S_REFILL) || (state == S_UNC);
  // One outstanding beat: no request in the cycle after an ack, and acks count only while requesting.
  assign req  = rst && bus_phase && !ack_gap;
  assign beat = req && io.bus_ack;

  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    io.mem_rdata  = '0;
    io.stall_req  = 1'b0;
    io.tag_wr     = 1'b0;
    io.cache_ok   = 1'b0;
    io.data_idx   = '0;
    io.data_we    = 1'b0;
    io.data_wsel  = '0;
    io.data_wdata = '0;
    io.bus_req    = 1'b0;
    io.bus_we     = 1'b0;
    io.bus_addr   = '0;
    io.bus_wdata  = '0;
    io.bus_sel    = '0;
    if (rst) begin
      case (state)
        S_IDLE: begin
          io.data_idx  = {index, io.mem_addr[5:2]};
          io.mem_rdata = io.data_rdata;
          if (unc_done) begin
            io.mem_rdata = unc_rdata;
          end else if (io.mem_ce) begin
            if (uncached) begin
              io.stall_req = 1'b1;
              next_state   = S_UNC;
            end else if (io.tag_hit) begin
              if (io.mem_we) begin
                io.data_we    = 1'b1;
                io.data_wsel  = io.mem_sel;
                io.data_wdata = io.mem_wdata;
                io.tag_wr     = 1'b1;
              end
            end else begin
              io.stall_req = 1'b1;
              next_cnt     = '0;
              next_state   = io.tag_write_back ? S_WB : S_REFILL;
            end
          end
        end
        S_WB: begin
          io.stall_req = 1'b1;
          io.bus_req   = req;
          io.bus_we    = 1'b1;
          io.bus_sel   = 4'hf;
          io.bus_addr  = io.tag_last_addr + 32'({cnt, 2'b00});
          io.data_idx  = {index, cnt};
          io.bus_wdata = io.data_rdata;
          if (beat) begin
            next_cnt = cnt + CW'(1);
            if (cnt == LAST) begin
              next_cnt   = '0;
              next_state = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          io.stall_req = 1'b1;
          io.bus_req   = req;
          io.bus_sel   = 4'hf;
          io.bus_addr  = {io.mem_addr[31:6], cnt, 2'b00};
          io.data_idx  = {index, cnt};
          if (beat) begin
            io.data_we    = 1'b1;
            io.data_wsel  = 4'hf;
            io.data_wdata = io.bus_rdata;
            next_cnt      = cnt + CW'(1);
            if (cnt == LAST) begin
              next_cnt   = '0;
              next_state = S_DONE;
            end
          end
        end
        S_DONE: begin
          // tag_hit is still low here, so the tag array writes the line clean.
          io.stall_req = 1'b1;
          io.cache_ok  = 1'b1;
          next_state   = S_IDLE;
        end
        S_UNC: begin
          io.stall_req = 1'b1;
          io.bus_req   = req;
          io.bus_we    = io.mem_we;
          io.bus_sel   = io.mem_sel;
          io.bus_addr  = io.mem_addr;
          io.bus_wdata = io.mem_wdata;
          if (beat) next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ack_gap   <= 1'b0;
      unc_done  <= 1'b0;
      unc_rdata <= '0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      ack_gap  <= beat;
      unc_done <= (state == S_UNC) && beat;
      if ((state == S_UNC) && beat) unc_rdata <= io.bus_rdata;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - bench for dcache_ctrl with tag/data array model, acking bus slave and beat scoreboard
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_ctrl_if io();
  dcache_ctrl #(.LINE_WORDS(16), .UNCACHED_SEG(3'b101)) dut (.clk(clk), .rst(rst), .io(io));

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_log[1024];
  int beats = 0;
  int checks = 0;
  int errors = 0;

  logic [17:0] tag_arr[256];
  logic        valid_arr[256];
  logic        dirty_arr[256];
  logic [31:0] dram[4096];
  logic        slave_ack, spur_ack;
  logic [31:0] slave_rdata;
  logic        pre_req;
  logic [7:0]  pre_idx;
  logic [17:0] pre_tag;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] wb_model(input logic [11:0] i);
    return {20'hC0FFE, i};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  logic [7:0] cur_idx;
  assign cur_idx           = io.mem_addr[13:6];
  assign io.tag_hit        = valid_arr[cur_idx] && (tag_arr[cur_idx] == io.mem_addr[31:14]);
  assign io.tag_write_back = valid_arr[cur_idx] && dirty_arr[cur_idx];
  assign io.tag_last_addr  = {tag_arr[cur_idx], cur_idx, 6'b0};
  assign io.data_rdata     = dram[io.data_idx];
  assign io.bus_ack        = slave_ack | spur_ack;
  assign io.bus_rdata      = slave_rdata;

  // Tag/data arrays and a bus slave that acks the cycle after it sees a request.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) begin
        valid_arr[i] <= 1'b0;
        dirty_arr[i] <= 1'b0;
        tag_arr[i]   <= '0;
      end
      slave_ack   <= 1'b0;
      slave_rdata <= '0;
    end else begin
      if (io.data_we) dram[io.data_idx] <= merge(dram[io.data_idx], io.data_wdata, io.data_wsel);
      if (io.cache_ok) begin
        tag_arr[cur_idx]   <= io.mem_addr[31:14];
        valid_arr[cur_idx] <= 1'b1;
        dirty_arr[cur_idx] <= io.tag_wr;
      end else if (io.tag_wr) begin
        dirty_arr[cur_idx] <= 1'b1;
      end
      if (pre_req) begin
        valid_arr[pre_idx] <= 1'b1;
        dirty_arr[pre_idx] <= 1'b1;
        tag_arr[pre_idx]   <= pre_tag;
        for (int w = 0; w < 16; w++) dram[{pre_idx, 4'(w)}] <= wb_model({pre_idx, 4'(w)});
      end
      slave_ack <= io.bus_req && !slave_ack;
      if (io.bus_req && !slave_ack) slave_rdata <= rd_model(io.bus_addr);
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst && io.bus_req && io.bus_ack) begin
      if (beats < 1024) obs_log[beats] <= {io.bus_we, io.bus_addr, io.bus_wdata, io.bus_sel};
      beats <= beats + 1;
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
    io.mem_ce = 1'b1; io.mem_we = we; io.mem_addr = addr; io.mem_sel = sel; io.mem_wdata = wdata;
  endtask

  task automatic run_access(output int cyc, output int ok_n, output int ok_at, output int we_n, output int twr_n);
    cyc = 0; ok_n = 0; ok_at = -1; we_n = 0; twr_n = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!io.stall_req) break;
      if (io.cache_ok) begin ok_n++; ok_at = cyc; end
      if (io.data_we) we_n++;
      if (io.tag_wr) twr_n++;
      cyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [153:0] all_outs();
    return {io.mem_rdata, io.stall_req, io.tag_wr, io.cache_ok, io.data_idx, io.data_we, io.data_wsel,
            io.data_wdata, io.bus_req, io.bus_we, io.bus_addr, io.bus_wdata, io.bus_sel};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'h0000_1044, 4'hf, 32'h1111_2222);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", all_outs()); end
    @(negedge clk);
    rst = 1'b1; io.mem_ce = 1'b0;
    #1;
    checks++; if ({io.stall_req, io.bus_req} !== 2'b00) begin errors++; $display("FAIL reset_idle got %b expected 00", {io.stall_req, io.bus_req}); end
  endtask

  task automatic test_spurious_ack();
    int b0;
    b0 = beats;
    @(negedge clk); spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    #1;
    checks++; if ({io.stall_req, io.bus_req, io.cache_ok} !== 3'b000) begin errors++; $display("FAIL spurious_ack_outs got %b expected 000", {io.stall_req, io.bus_req, io.cache_ok}); end
    @(negedge clk); #3;
    checks++; if (beats !== b0) begin errors++; $display("FAIL spurious_ack_beats got %0d expected %0d", beats, b0); end
  endtask

  task automatic test_load_miss_clean();
    int b0, cyc, ok_n, ok_at, we_n, twr_n;
    beat_t e;
    b0 = beats;
    for (int w = 0; w < 16; w++) exp_q.push_back('{we: 1'b0, addr: 32'h1040 + 32'(4*w), wdata: 32'h0, sel: 4'hf});
    @(negedge clk);
    drive(1'b0, 32'h0000_1040, 4'hf, 32'h0);
    run_access(cyc, ok_n, ok_at, we_n, twr_n);
    checks++; if (cyc !== 49) begin errors++; $display("FAIL clean_latency got %0d expected 49", cyc); end
    checks++; if (ok_n !== 1 || ok_at !== cyc - 1) begin errors++; $display("FAIL clean_cache_ok got n=%0d at=%0d expected n=1 at=%0d", ok_n, ok_at, cyc - 1); end
    checks++; if (we_n !== 16 || twr_n !== 0) begin errors++; $display("FAIL clean_strobes got we=%0d twr=%0d expected 16 0", we_n, twr_n); end
    checks++; if (io.mem_rdata !== rd_model(32'h1040)) begin errors++; $display("FAIL clean_rdata got %h expected %h", io.mem_rdata, rd_model(32'h1040)); end
    checks++; if (beats - b0 !== 16) begin errors++; $display("FAIL clean_beat_count got %0d expected 16", beats - b0); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      checks++; if (obs_log[b0 + k] !== e) begin errors++; $display("FAIL clean_beat%0d got %h expected %h", k, obs_log[b0 + k], e); end
    end
    @(negedge clk); io.mem_ce = 1'b0;
  endtask

  task automatic test_store_hit();
    logic [31:0] old, expw;
    old  = rd_model(32'h1044);
    expw = {old[31:16], 16'hCCDD};
    @(negedge clk);
    drive(1'b1, 32'h0000_1044, 4'b0011, 32'hAABB_CCDD);
    #1;
    checks++; if ({io.stall_req, io.data_we, io.tag_wr, io.bus_req} !== 4'b0110) begin errors++; $display("FAIL store_hit_strobes got %b expected 0110", {io.stall_req, io.data_we, io.tag_wr, io.bus_req}); end
    checks++; if (io.data_idx !== 12'h411) begin errors++; $display("FAIL store_hit_idx got %h expected 411", io.data_idx); end
    checks++; if ({io.data_wsel, io.data_wdata} !== {4'b0011, 32'hAABB_CCDD}) begin errors++; $display("FAIL store_hit_data got %h expected 3aabbccdd", {io.data_wsel, io.data_wdata}); end
    @(posedge clk); #1;
    checks++; if (dram[12'h411] !== expw) begin errors++; $display("FAIL store_hit_ram got %h expected %h", dram[12'h411], expw); end
    checks++; if (dirty_arr[8'h41] !== 1'b1) begin errors++; $display("FAIL store_hit_dirty got %b expected 1", dirty_arr[8'h41]); end
    @(negedge clk); io.mem_ce = 1'b0;
  endtask

  task automatic test_dirty_miss();
    int b0, cyc, ok_n, ok_at, we_n, twr_n;
    beat_t e;
    @(negedge clk); pre_idx = 8'h01; pre_tag = 18'h1; pre_req = 1'b1;
    @(negedge clk); pre_req = 1'b0;
    b0 = beats;
    for (int w = 0; w < 16; w++) exp_q.push_back('{we: 1'b1, addr: 32'h4040 + 32'(4*w), wdata: wb_model({8'h01, 4'(w)}), sel: 4'hf});
    for (int w = 0; w < 16; w++) exp_q.push_back('{we: 1'b0, addr: 32'h1_4040 + 32'(4*w), wdata: 32'h0, sel: 4'hf});
    drive(1'b0, 32'h0001_4040, 4'hf, 32'h0);
    run_access(cyc, ok_n, ok_at, we_n, twr_n);
    checks++; if (cyc !== 97) begin errors++; $display("FAIL dirty_latency got %0d expected 97", cyc); end
    checks++; if (ok_n !== 1 || ok_at !== cyc - 1 || twr_n !== 0) begin errors++; $display("FAIL dirty_cache_ok got n=%0d at=%0d twr=%0d expected 1 %0d 0", ok_n, ok_at, twr_n, cyc - 1); end
    checks++; if ({tag_arr[1], dirty_arr[1], valid_arr[1]} !== {18'h5, 1'b0, 1'b1}) begin errors++; $display("FAIL dirty_tag_state got %h expected %h", {tag_arr[1], dirty_arr[1], valid_arr[1]}, {18'h5, 1'b0, 1'b1}); end
    checks++; if (io.mem_rdata !== rd_model(32'h1_4040)) begin errors++; $display("FAIL dirty_rdata got %h expected %h", io.mem_rdata, rd_model(32'h1_4040)); end
    checks++; if (beats - b0 !== 32) begin errors++; $display("FAIL dirty_beat_count got %0d expected 32", beats - b0); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      checks++; if (obs_log[b0 + k] !== e) begin errors++; $display("FAIL dirty_beat%0d got %h expected %h", k, obs_log[b0 + k], e); end
    end
    @(negedge clk); io.mem_ce = 1'b0;
  endtask

  task automatic test_uncached();
    int b0, cyc, ok_n, ok_at, we_n, twr_n;
    beat_t e;
    b0 = beats;
    exp_q.push_back('{we: 1'b0, addr: 32'hA000_0010, wdata: 32'h0, sel: 4'b0110});
    @(negedge clk);
    drive(1'b0, 32'hA000_0010, 4'b0110, 32'h0);
    run_access(cyc, ok_n, ok_at, we_n, twr_n);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL unc_latency got %0d expected 3", cyc); end
    checks++; if ({ok_n, we_n, twr_n} !== {32'd0, 32'd0, 32'd0} || {io.data_we, io.tag_wr, io.cache_ok} !== 3'b000) begin errors++; $display("FAIL unc_strobes got ok=%0d we=%0d twr=%0d expected 0 0 0", ok_n, we_n, twr_n); end
    checks++; if (io.mem_rdata !== rd_model(32'hA000_0010)) begin errors++; $display("FAIL unc_rdata got %h expected %h", io.mem_rdata, rd_model(32'hA000_0010)); end
    checks++; if (beats - b0 !== 1) begin errors++; $display("FAIL unc_beat_count got %0d expected 1", beats - b0); end
    e = exp_q.pop_front();
    checks++; if (obs_log[b0] !== e) begin errors++; $display("FAIL unc_beat got %h expected %h", obs_log[b0], e); end
    @(negedge clk); io.mem_ce = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    int b0, cyc, ok_n, ok_at, we_n, twr_n;
    bit hit7;
    beat_t e;
    b0 = beats;
    hit7 = 1'b0;
    @(negedge clk);
    drive(1'b0, 32'h0000_2080, 4'hf, 32'h0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #3;
      if (beats - b0 == 7) begin hit7 = 1'b1; break; end
    end
    checks++; if (!hit7) begin errors++; $display("FAIL midreset_reach_cnt7 got %0d beats expected 7", beats - b0); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (all_outs() !== '0) begin errors++; $display("FAIL midreset_outputs got %h expected 0", all_outs()); end
    rst = 1'b1;
    #1;
    checks++; if ({io.stall_req, io.bus_req} !== 2'b10) begin errors++; $display("FAIL midreset_idle got %b expected 10", {io.stall_req, io.bus_req}); end
    b0 = beats;
    for (int w = 0; w < 16; w++) exp_q.push_back('{we: 1'b0, addr: 32'h2080 + 32'(4*w), wdata: 32'h0, sel: 4'hf});
    run_access(cyc, ok_n, ok_at, we_n, twr_n);
    checks++; if (cyc !== 49 || ok_n !== 1) begin errors++; $display("FAIL midreset_restart got cyc=%0d ok=%0d expected 49 1", cyc, ok_n); end
    checks++; if (io.mem_rdata !== rd_model(32'h2080)) begin errors++; $display("FAIL midreset_rdata got %h expected %h", io.mem_rdata, rd_model(32'h2080)); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      checks++; if (obs_log[b0 + k] !== e) begin errors++; $display("FAIL midreset_beat%0d got %h expected %h", k, obs_log[b0 + k], e); end
    end
    @(negedge clk); io.mem_ce = 1'b0;
  endtask

  initial begin
    rst = 1'b0; spur_ack = 1'b0; pre_req = 1'b0; pre_idx = '0; pre_tag = '0;
    io.mem_ce = 1'b0; io.mem_we = 1'b0; io.mem_addr = '0; io.mem_sel = '0; io.mem_wdata = '0;
    test_reset();
    test_spurious_ack();
    test_load_miss_clean();
    test_store_hit();
    test_dirty_miss();
    test_uncached();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
